// File: rtl/uart_fifo_bridge.sv
// uart_fifo_bridge
//   Serial-side companion of the core's memory-mapped UART port. An 8N1
//   receiver deserializes rxd into a show-ahead RX FIFO read by the core, and
//   an 8N1 transmitter drains a TX FIFO written by the core onto txd.
//
// Ports
//   clk, rst      system clock; asynchronous active-high reset
//   rxd           serial input (asynchronous to clk, idles high)
//   txd           serial output (registered, idles high)
//   rx_q          RX FIFO head byte, valid while rx_empty=0
//   rx_empty      RX FIFO empty
//   rx_rdreq      pop the RX head at the end of this cycle
//   tx_data       byte to enqueue into the TX FIFO
//   tx_wrreq      enqueue tx_data at the end of this cycle
//   tx_full       TX FIFO full
//   rx_overrun    1-cycle pulse: received byte dropped, RX FIFO was full
//   rx_frame_err  1-cycle pulse: stop bit sampled low, byte dropped
//
// Core-side handshake: rx_rdreq acts only when rx_empty=0 and tx_wrreq acts
// only when tx_full=0, both judged on the state before the clock edge; a
// request made otherwise is silently ignored and changes nothing.

module uart_fifo_bridge #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       txd,
  output logic [7:0] rx_q,
  output logic       rx_empty,
  input  logic       rx_rdreq,
  input  logic [7:0] tx_data,
  input  logic       tx_wrreq,
  output logic       tx_full,
  output logic       rx_overrun,
  output logic       rx_frame_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int CW    = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // ---------------------------------------------------------------------------
  // rxd synchronizer. sync_vld_q marks when rs_q carries a real sample of the
  // line rather than its reset value, so a line held low out of reset is never
  // mistaken for a falling edge.
  // ---------------------------------------------------------------------------
  logic       rs_meta_q, rs_q, rs_prev_q;
  logic [1:0] sync_vld_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_meta_q  <= 1'b1;
      rs_q       <= 1'b1;
      rs_prev_q  <= 1'b0;
      sync_vld_q <= 2'b00;
    end else begin
      rs_meta_q  <= rxd;
      rs_q       <= rs_meta_q;
      // Only a genuinely observed high level arms the start-edge detector.
      rs_prev_q  <= rs_q & sync_vld_q[1];
      sync_vld_q <= {sync_vld_q[0], 1'b1};
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage and pointers (both FIFOs identical)
  // ---------------------------------------------------------------------------
  logic [PW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [PW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [7:0]    rx_mem_q [DEPTH];
  logic [7:0]    rx_mem_d [DEPTH];
  logic [7:0]    tx_mem_q [DEPTH];
  logic [7:0]    tx_mem_d [DEPTH];
  logic          rx_full, tx_empty;
  logic          rx_push, rx_pop, tx_push, tx_pop;
  logic [7:0]    tx_head;

  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[PW-1] != rx_rd_q[PW-1]) &&
                    (rx_wr_q[PW-2:0] == rx_rd_q[PW-2:0]);
  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[PW-1] != tx_rd_q[PW-1]) &&
                    (tx_wr_q[PW-2:0] == tx_rd_q[PW-2:0]);

  assign rx_q    = rx_mem_q[rx_rd_q[PW-2:0]];
  assign tx_head = tx_mem_q[tx_rd_q[PW-2:0]];

  assign rx_pop  = rx_rdreq && !rx_empty;
  assign tx_push = tx_wrreq && !tx_full;

  // ---------------------------------------------------------------------------
  // RX FSM
  // ---------------------------------------------------------------------------
  uart_state_e   rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_idx_q, rx_idx_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          rx_overrun_q, rx_overrun_d;
  logic          rx_frame_err_q, rx_frame_err_d;

  always_comb begin
    rx_state_d     = rx_state_q;
    rx_cnt_d       = rx_cnt_q;
    rx_idx_d       = rx_idx_q;
    rx_sh_d        = rx_sh_q;
    rx_overrun_d   = 1'b0;
    rx_frame_err_d = 1'b0;
    rx_push        = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        if (rs_prev_q && !rs_q) begin
          rx_state_d = ST_START;
          rx_cnt_d   = HALF_LAST;
        end
      end
      ST_START: begin
        if (rx_cnt_q == '0) begin
          if (!rs_q) begin
            rx_state_d = ST_DATA;
            rx_idx_d   = 3'd0;
            rx_cnt_d   = BIT_LAST;
          end else begin
            // Line back high at mid-start: a glitch, not a frame.
            rx_state_d = ST_IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      ST_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_sh_d  = {rs_q, rx_sh_q[7:1]};
          rx_cnt_d = BIT_LAST;
          if (rx_idx_q == 3'd7) begin
            rx_state_d = ST_STOP;
          end else begin
            rx_idx_d = rx_idx_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      ST_STOP: begin
        if (rx_cnt_q == '0) begin
          rx_state_d = ST_IDLE;
          if (!rs_q) begin
            rx_frame_err_d = 1'b1;
          end else if (rx_full) begin
            rx_overrun_d = 1'b1;
          end else begin
            rx_push = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // TX FSM. The popped byte lives in tx_sh_q for the whole frame, so its FIFO
  // slot is free as soon as the start bit begins.
  // ---------------------------------------------------------------------------
  uart_state_e   tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_idx_q, tx_idx_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          txd_q, txd_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_sh_d    = tx_sh_q;
    txd_d      = txd_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      ST_IDLE: begin
        txd_d = 1'b1;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_sh_d    = tx_head;
          txd_d      = 1'b0;
          tx_state_d = ST_START;
          tx_cnt_d   = BIT_LAST;
        end
      end
      ST_START: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = ST_DATA;
          tx_idx_d   = 3'd0;
          tx_cnt_d   = BIT_LAST;
          txd_d      = tx_sh_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
      end
      ST_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = BIT_LAST;
          if (tx_idx_q == 3'd7) begin
            tx_state_d = ST_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_idx_d = tx_idx_q + 3'd1;
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
            txd_d    = tx_sh_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
      end
      ST_STOP: begin
        // Returning to IDLE costs one cycle before the next start bit.
        if (tx_cnt_q == '0) begin
          tx_state_d = ST_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO next state
  // ---------------------------------------------------------------------------
  always_comb begin
    rx_mem_d = rx_mem_q;
    rx_wr_d  = rx_wr_q;
    rx_rd_d  = rx_rd_q;
    tx_mem_d = tx_mem_q;
    tx_wr_d  = tx_wr_q;
    tx_rd_d  = tx_rd_q;
    if (rx_push) begin
      rx_mem_d[rx_wr_q[PW-2:0]] = rx_sh_q;
      rx_wr_d = rx_wr_q + PTR_ONE;
    end
    if (rx_pop) begin
      rx_rd_d = rx_rd_q + PTR_ONE;
    end
    if (tx_push) begin
      tx_mem_d[tx_wr_q[PW-2:0]] = tx_data;
      tx_wr_d = tx_wr_q + PTR_ONE;
    end
    if (tx_pop) begin
      tx_rd_d = tx_rd_q + PTR_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q     <= ST_IDLE;
      rx_cnt_q       <= '0;
      rx_idx_q       <= '0;
      rx_sh_q        <= '0;
      rx_overrun_q   <= 1'b0;
      rx_frame_err_q <= 1'b0;
      tx_state_q     <= ST_IDLE;
      tx_cnt_q       <= '0;
      tx_idx_q       <= '0;
      tx_sh_q        <= '0;
      txd_q          <= 1'b1;
      rx_wr_q        <= '0;
      rx_rd_q        <= '0;
      tx_wr_q        <= '0;
      tx_rd_q        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rx_mem_q[i] <= '0;
        tx_mem_q[i] <= '0;
      end
    end else begin
      rx_state_q     <= rx_state_d;
      rx_cnt_q       <= rx_cnt_d;
      rx_idx_q       <= rx_idx_d;
      rx_sh_q        <= rx_sh_d;
      rx_overrun_q   <= rx_overrun_d;
      rx_frame_err_q <= rx_frame_err_d;
      tx_state_q     <= tx_state_d;
      tx_cnt_q       <= tx_cnt_d;
      tx_idx_q       <= tx_idx_d;
      tx_sh_q        <= tx_sh_d;
      txd_q          <= txd_d;
      rx_wr_q        <= rx_wr_d;
      rx_rd_q        <= rx_rd_d;
      tx_wr_q        <= tx_wr_d;
      tx_rd_q        <= tx_rd_d;
      rx_mem_q       <= rx_mem_d;
      tx_mem_q       <= tx_mem_d;
    end
  end

  assign txd          = txd_q;
  assign rx_overrun   = rx_overrun_q;
  assign rx_frame_err = rx_frame_err_q;

endmodule
